// File: rtl/fifo_uart_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_pkg
// Shared types and constants for the FIFO-fed UART transmitter.
//   tx_state_t  : transmitter FSM encoding. PARITY is always declared so the
//                 state encoding does not change when the parity option is
//                 switched on or off.
//   OVERSAMPLE  : oversample ticks per start/data/parity bit cell.
// -----------------------------------------------------------------------------
package fifo_uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage : fifo_uart_pkg

// File: rtl/fifo_uart_tx_baud_gen.sv
// -----------------------------------------------------------------------------
// baud_gen
// Mod-DVSR counter producing the 16x oversample tick for the UART transmitter.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset
//   clr    in  synchronous clear; holds the counter at 0 while asserted
//   s_tick out high in the cycle where the count equals DVSR-1
// Parameters: DVSR (clk cycles per tick, >= 1), DVSR_W (counter width,
// 2**DVSR_W > DVSR).
// -----------------------------------------------------------------------------
module baud_gen #(
  parameter int DVSR   = 54,
  parameter int DVSR_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic s_tick
);

  localparam logic [DVSR_W-1:0] CNT_LAST = DVSR_W'(DVSR - 1);

  logic [DVSR_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // flops sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gated by clr so a DVSR of 1 does not tick while the transmitter idles.
  assign s_tick = ~clr & (cnt_q == CNT_LAST);

endmodule : baud_gen

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Pops bytes from the byte-read FIFO whenever it is non-empty and sends each
// one as an 8N1 UART frame (LSB first) on tx, using a 16x oversample tick.
// Optional build macro: FIFO_UART_TX_PARITY_EN adds an even-parity bit cell
// between the last data bit and the stop bit.
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   empty         in   FIFO empty flag
//   r_data        in   FIFO head byte, valid while empty=0
//   rd            out  one-cycle FIFO pop strobe
//   tx            out  registered serial line, idle high
//   tx_busy       out  high from the pop until the end of the stop bit
//   tx_done_tick  out  one-cycle pulse in the final cycle of the stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR       = 54,
  parameter int DVSR_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  // The tick counter must reach both OVERSAMPLE-1 and SB_TICK-1.
  localparam int TICK_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int NT_W     = $clog2(TICK_MAX);
  localparam int NB_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [NT_W-1:0] CELL_LAST = NT_W'(OVERSAMPLE - 1);
  localparam logic [NT_W-1:0] STOP_LAST = NT_W'(SB_TICK - 1);
  localparam logic [NB_W-1:0] DATA_LAST = NB_W'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic [NT_W-1:0]       n_tick_q, n_tick_d;
  logic [NB_W-1:0]       n_bit_q, n_bit_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  tx_q, tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic s_tick;
  logic cell_end;

  baud_gen #(
    .DVSR   (DVSR),
    .DVSR_W (DVSR_W)
  ) u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_q == IDLE),
    .s_tick (s_tick)
  );

  assign cell_end = s_tick & (n_tick_q == CELL_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      n_tick_q <= '0;
      n_bit_q  <= '0;
      b_q      <= '0;
      tx_q     <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      n_tick_q <= n_tick_d;
      n_bit_q  <= n_bit_d;
      b_q      <= b_d;
      tx_q     <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    n_tick_d = n_tick_q;
    n_bit_d  = n_bit_q;
    b_d      = b_q;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rd) begin
          b_d      = r_data;
          n_tick_d = '0;
          state_d  = START;
`ifdef FIFO_UART_TX_PARITY_EN
          // Latched with the byte, before any shifting destroys it.
          par_d    = ^r_data;
`endif
        end
      end
      START: begin
        if (cell_end) begin
          n_tick_d = '0;
          n_bit_d  = '0;
          state_d  = DATA;
        end else if (s_tick) begin
          n_tick_d = n_tick_q + 1'b1;
        end
      end
      DATA: begin
        if (cell_end) begin
          n_tick_d = '0;
          b_d      = b_q >> 1;
          if (n_bit_q == DATA_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            n_bit_d = n_bit_q + 1'b1;
          end
        end else if (s_tick) begin
          n_tick_d = n_tick_q + 1'b1;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (cell_end) begin
          n_tick_d = '0;
          state_d  = STOP;
        end else if (s_tick) begin
          n_tick_d = n_tick_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (s_tick && (n_tick_q == STOP_LAST)) begin
          n_tick_d = '0;
          state_d  = IDLE;
        end else if (s_tick) begin
          n_tick_d = n_tick_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Pop is suppressed while reset is held: the byte could not be captured,
    // so popping it would silently drop it.
    rd           = (state_q == IDLE) & ~empty & ~reset;
    tx_busy      = (state_q != IDLE) | rd;
    tx_done_tick = (state_q == STOP) & s_tick & (n_tick_q == STOP_LAST);
    tx_d         = 1'b1;
    unique case (state_q)
      IDLE:   tx_d = 1'b1;
      START:  tx_d = 1'b0;
      DATA:   tx_d = b_q[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_d = par_q;
`endif
      STOP:   tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // Line driven straight from a flop, so it lags the FSM by one cycle.
  assign tx = tx_q;

endmodule : fifo_uart_tx

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Scoreboard bench for fifo_uart_tx at DVSR=2 (32 clk per bit cell).
// dut uses SB_TICK=16, dut2 uses SB_TICK=32. Bytes pushed into the FIFO model
// are also queued as expectations; each pop opens a frame whose bit cells are
// compared against the queued byte at cell centres.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int DVSR  = 2;
  localparam int CELL  = 16 * DVSR;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NC    = 10;  // start + 8 data + parity
`else
  localparam int NC    = 9;   // start + 8 data
`endif
  localparam int STOP1 = 16 * DVSR;
  localparam int STOP2 = 32 * DVSR;

  logic       clk;
  logic       rst, rst2;
  logic       empty, empty2;
  logic [7:0] r_data, r_data2;
  logic       rd, tx, tx_busy, tx_done_tick;
  logic       rd2, tx2, busy2, done2;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  // Monitor state
  int          rd_cnt = 0;
  int          done_cnt = 0;
  int          f_rd = 0;
  logic        active = 1'b0;
  logic [10:0] f_bits = '0;
  int          expect_rd_at = -1;

  fifo_uart_tx #(
    .DATA_WIDTH (8),
    .SB_TICK    (16),
    .DVSR       (DVSR),
    .DVSR_W     (8)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .empty        (empty),
    .r_data       (r_data),
    .rd           (rd),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  fifo_uart_tx #(
    .DATA_WIDTH (8),
    .SB_TICK    (32),
    .DVSR       (DVSR),
    .DVSR_W     (8)
  ) dut2 (
    .clk          (clk),
    .reset        (rst2),
    .empty        (empty2),
    .r_data       (r_data2),
    .rd           (rd2),
    .tx           (tx2),
    .tx_busy      (busy2),
    .tx_done_tick (done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic fifo_refresh();
    empty  = (fifo_q.size() == 0);
    r_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    fifo_refresh();
  endtask

  task automatic wait_dones(input int target, input int budget, input string tag);
    int i = 0;
    while (done_cnt < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    check(tag, done_cnt, target);
  endtask

  // FIFO model: a pop seen mid-cycle takes effect at the following edge.
  initial begin
    logic rd_seen;
    forever begin
      @(negedge clk);
      rd_seen = rd;
      @(posedge clk);
      #1;
      if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_refresh();
    end
  end

  // Frame monitor / scoreboard for dut.
  initial begin
    logic [7:0] b;
    int         off;
    forever begin
      @(negedge clk);
      if (rst) begin
        active       = 1'b0;
        expect_rd_at = -1;
      end else begin
        if (expect_rd_at == cyc) check("rd_gap", 32'(rd), 1);
        if (rd) begin
          rd_cnt++;
          check("rd_nonempty", 32'(empty), 0);
          check("busy_at_pop", 32'(tx_busy), 1);
          if (exp_q.size() == 0) begin
            check("sb_underflow", exp_q.size(), 1);
          end else begin
            b         = exp_q.pop_front();
            f_bits    = '0;
            f_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) f_bits[1+i] = b[i];
            f_bits[9] = ^b;
            f_rd      = cyc;
            active    = 1'b1;
          end
        end
        if (active) begin
          off = cyc - (f_rd + 2);
          if (off >= 0 && (off % CELL) == CELL / 2 && (off / CELL) < NC)
            check($sformatf("cell%0d", off / CELL), 32'(tx), 32'(f_bits[off / CELL]));
          if (off == NC * CELL + STOP1 / 2) check("stop_cell", 32'(tx), 1);
        end
        if (tx_done_tick) begin
          done_cnt++;
          check("done_in_frame", 32'(active), 1);
          if (active) check("done_span", cyc - f_rd + 1, NC * CELL + STOP1 + 1);
          active = 1'b0;
          if (!empty) expect_rd_at = cyc + 1;
        end
      end
    end
  end

  initial begin
    int r0, d0, i, fr, target;
    int irdn, itx, ib;
    int c2, d2n, d2at, xrd2;
    logic found;

    rst = 1'b1; rst2 = 1'b1;
    empty = 1'b1; r_data = 8'h00;
    empty2 = 1'b1; r_data2 = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_rd", 32'(rd), 0);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_done", 32'(tx_done_tick), 0);
    check("rst_tx2", 32'(tx2), 1);
    @(posedge clk);
    #1;
    rst = 1'b0; rst2 = 1'b0;

    // Empty FIFO for 500 cycles
    irdn = 0; itx = 0; ib = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (rd !== 1'b0) irdn++;
      if (tx !== 1'b1) itx++;
      if (tx_busy !== 1'b0) ib++;
    end
    check("idle_rd", irdn, 0);
    check("idle_tx", itx, 0);
    check("idle_busy", ib, 0);

    // Single byte 0x0F
    r0 = rd_cnt; d0 = done_cnt;
    @(posedge clk); #2;
    push(8'h0F);
    wait_dones(d0 + 1, 2000, "wait_0f");
    repeat (40) @(negedge clk);
    check("rd_once_0f", rd_cnt - r0, 1);
    check("done_once_0f", done_cnt - d0, 1);

    // Back-to-back 0xAB, 0xCD
    r0 = rd_cnt; d0 = done_cnt;
    @(posedge clk); #2;
    push(8'hAB);
    push(8'hCD);
    wait_dones(d0 + 2, 3000, "wait_abcd");
    repeat (40) @(negedge clk);
    check("rd_twice_abcd", rd_cnt - r0, 2);

    // Reset during data bit 3 of 0x55 with 0x3C still queued
    r0 = rd_cnt; d0 = done_cnt;
    @(posedge clk); #2;
    push(8'h55);
    push(8'h3C);
    i = 0;
    while (rd_cnt < r0 + 1 && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("rd_55", rd_cnt, r0 + 1);
    fr     = f_rd;
    target = fr + 2 + 4 * CELL + 10;
    i = 0;
    while (cyc < target && i < 1000) begin
      @(posedge clk);
      i++;
    end
    #3;
    check("tx_pre_rst", 32'(tx), 0);
    rst = 1'b1;
    #1;
    check("tx_async_rst", 32'(tx), 1);
    check("rd_in_rst", 32'(rd), 0);
    repeat (3) @(posedge clk);
    check("no_done_55", done_cnt, d0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rd_first_cycle", 32'(rd), 1);
    wait_dones(d0 + 1, 2000, "wait_3c");
    repeat (40) @(negedge clk);
    check("rd_55_3c", rd_cnt - r0, 2);
    check("done_only_3c", done_cnt - d0, 1);

    // Parity pattern bytes (frames carry a parity cell when enabled)
    r0 = rd_cnt; d0 = done_cnt;
    @(posedge clk); #2;
    push(8'h0F);
    push(8'h07);
    wait_dones(d0 + 2, 3000, "wait_0f07");
    repeat (40) @(negedge clk);
    check("rd_0f07", rd_cnt - r0, 2);

    // SB_TICK=32 instance: 64-clk stop cell, single done pulse
    @(posedge clk); #2;
    empty2 = 1'b0; r_data2 = 8'h03;
    found = 1'b0; c2 = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (rd2) begin
        found = 1'b1;
        c2    = cyc;
      end
    end
    check("rd2_seen", 32'(found), 1);
    @(posedge clk); #1;
    empty2 = 1'b1; r_data2 = 8'h00;
    d2n = 0; d2at = -1; xrd2 = 0;
    while (cyc < c2 + NC * CELL + STOP2 + 60) begin
      @(negedge clk);
      if (done2) begin
        d2n++;
        d2at = cyc - c2;
      end
      if (rd2) xrd2++;
      if (cyc - c2 == 2 + CELL / 2) check("sb32_start", 32'(tx2), 0);
      if (cyc - c2 == 2 + NC * CELL - 1) check("sb32_pre_stop", 32'(tx2), 0);
      if (cyc - c2 == 2 + NC * CELL) check("sb32_stop_first", 32'(tx2), 1);
      if (cyc - c2 == 2 + NC * CELL + STOP2 - 1) check("sb32_stop_last", 32'(tx2), 1);
    end
    check("sb32_done_count", d2n, 1);
    check("sb32_done_time", d2at, NC * CELL + STOP2);
    check("sb32_no_extra_rd", xrd2, 0);

    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fifo_uart_tx
